// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into one-cycle press/release/short/long/double/repeat pulses.
// Optional auto-repeat while long-held is enabled by defining BUTTON_REPEAT_EN.
module button_event_decoder #(
    parameter logic [31:0] LONG_CYCLES   = 32'd50000000,
    parameter logic [31:0] GAP_CYCLES    = 32'd15000000,
    parameter logic [31:0] REPEAT_CYCLES = 32'd10000000,
    parameter int          CNT_W         = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESSED   = 3'd1,
        ST_LONG_HELD = 3'd2,
        ST_WAIT_GAP  = 3'd3,
        ST_SECOND    = 3'd4
    } state_t;

    // The sample that enters PRESSED/WAIT_GAP is already the first counted sample,
    // and cnt is 0 on the next one, so the N-th sample sees cnt == N-2.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 32'd2);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 32'd2);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             btn_q_r;
    logic             rise_s;
    logic             fall_s;
    logic             cnt_clr_s;
    logic             press_s;
    logic             release_s;
    logic             short_s;
    logic             long_s;
    logic             double_s;

`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 32'd1);
    logic repeat_s;
`else
    logic unused_repeat_cfg_s;
    assign unused_repeat_cfg_s = ^REPEAT_CYCLES;
    assign repeat_pulse        = 1'b0;
`endif

    assign rise_s = btn_level & ~btn_q_r;
    assign fall_s = ~btn_level & btn_q_r;

    // Next-state and pulse decode for the press classifier.
    always_comb begin
        next_state_s = state_r;
        cnt_clr_s    = 1'b0;
        press_s      = 1'b0;
        release_s    = 1'b0;
        short_s      = 1'b0;
        long_s       = 1'b0;
        double_s     = 1'b0;
`ifdef BUTTON_REPEAT_EN
        repeat_s     = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    next_state_s = ST_PRESSED;
                    press_s      = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (fall_s) begin
                    next_state_s = ST_WAIT_GAP;
                    release_s    = 1'b1;
                end else if (cnt_r == LONG_LAST) begin
                    next_state_s = ST_LONG_HELD;
                    long_s       = 1'b1;
                end else begin
                    next_state_s = ST_PRESSED;
                end
            end
            ST_LONG_HELD: begin
                if (fall_s) begin
                    next_state_s = ST_IDLE;
                    release_s    = 1'b1;
`ifdef BUTTON_REPEAT_EN
                end else if (cnt_r == REP_LAST) begin
                    next_state_s = ST_LONG_HELD;
                    repeat_s     = 1'b1;
                    cnt_clr_s    = 1'b1;
`endif
                end else begin
                    next_state_s = ST_LONG_HELD;
                end
            end
            ST_WAIT_GAP: begin
                if (rise_s) begin
                    next_state_s = ST_SECOND;
                    press_s      = 1'b1;
                end else if (cnt_r == GAP_LAST) begin
                    next_state_s = ST_IDLE;
                    short_s      = 1'b1;
                end else begin
                    next_state_s = ST_WAIT_GAP;
                end
            end
            ST_SECOND: begin
                if (fall_s) begin
                    next_state_s = ST_IDLE;
                    release_s    = 1'b1;
                    double_s     = 1'b1;
                end else begin
                    next_state_s = ST_SECOND;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_clr_s    = 1'b1;
            end
        endcase
    end

    // State, saturating sample counter, edge-detect history and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            btn_q_r       <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            btn_q_r       <= btn_level;
            if ((next_state_s != state_r) || cnt_clr_s) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            press_pulse   <= press_s;
            release_pulse <= release_s;
            short_press   <= short_s;
            long_press    <= long_s;
            double_click  <= double_s;
        end
    end

`ifdef BUTTON_REPEAT_EN
    // Auto-repeat pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= repeat_s;
        end
    end
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: run-length reference model checked every cycle,
// directed scenarios pinned with literal pulse counts, then randomized press patterns.
module tb_button_event_decoder;

    localparam int L = 8;
    localparam int G = 5;
    localparam int R = 3;
`ifdef BUTTON_REPEAT_EN
    localparam int EXP_REP20 = 4;
`else
    localparam int EXP_REP20 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_level = 1'b0;
    logic press_pulse, release_pulse, short_press, long_press, double_click, repeat_pulse;

    button_event_decoder #(
        .LONG_CYCLES(32'd8), .GAP_CYCLES(32'd5), .REPEAT_CYCLES(32'd3), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .btn_level(btn_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .short_press(short_press), .long_press(long_press),
        .double_click(double_click), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int dut_cnt[6];
    int mdl_cnt[6];
    int dut_snap[6];
    int mdl_snap[6];
    string names[6] = '{"press", "release", "short", "long", "double", "repeat"};

    // Reference model: run lengths of the current press and of the gap after a short first press.
    logic m_prev;
    int   m_kind;   // 0 none/ignored, 1 first press, 2 second press
    int   m_high;
    int   m_low;
    bit   m_wait;

    initial begin
        logic [5:0] e;
        logic [5:0] got;
        logic b;
        for (int i = 0; i < 6; i++) begin
            dut_cnt[i] = 0; mdl_cnt[i] = 0; dut_snap[i] = 0; mdl_snap[i] = 0;
        end
        m_prev = 1'b1; m_kind = 0; m_high = 0; m_low = 0; m_wait = 1'b0;
        forever begin
            @(posedge clk);
            b = btn_level;
            e = 6'b0;
            if (rst) begin
                m_prev = 1'b1; m_kind = 0; m_high = 0; m_low = 0; m_wait = 1'b0;
            end else begin
                if (b && !m_prev) begin
                    e[0] = 1'b1;
                    m_kind = m_wait ? 2 : 1;
                    m_wait = 1'b0;
                    m_high = 1;
                end else if (b && m_kind != 0) begin
                    m_high++;
                    if (m_kind == 1 && m_high == L) e[3] = 1'b1;
`ifdef BUTTON_REPEAT_EN
                    if (m_kind == 1 && m_high > L && ((m_high - L) % R) == 0) e[5] = 1'b1;
`endif
                end else if (!b && m_prev) begin
                    if (m_kind == 1) begin
                        e[1] = 1'b1;
                        if (m_high < L) begin
                            m_wait = 1'b1;
                            m_low  = 1;
                        end
                    end else if (m_kind == 2) begin
                        e[1] = 1'b1;
                        e[4] = 1'b1;
                    end
                    m_kind = 0;
                end else if (!b && m_wait) begin
                    m_low++;
                    if (m_low == G) begin
                        e[2]   = 1'b1;
                        m_wait = 1'b0;
                    end
                end
                m_prev = b;
            end
            #1;
            cyc++;
            got = {repeat_pulse, double_click, long_press, short_press, release_pulse, press_pulse};
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] !== e[i]) begin
                    failures++;
                    $display("FAIL %s cycle=%0d got=%b exp=%b", names[i], cyc, got[i], e[i]);
                end
                if (got[i] === 1'b1) dut_cnt[i]++;
                if (e[i]) mdl_cnt[i]++;
            end
        end
    end

    task automatic drive(input logic lvl, input int n);
        for (int k = 0; k < n; k++) begin
            btn_level = lvl;
            @(negedge clk);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 6; i++) begin
            dut_snap[i] = dut_cnt[i];
            mdl_snap[i] = mdl_cnt[i];
        end
    endtask

    // Compare pulse counts since the last snapshot (DUT and model) against hand-computed values.
    task automatic expect_counts(input string nm, input int p, input int r, input int s,
                                 input int l, input int d, input int rp);
        int ex[6];
        ex = '{p, r, s, l, d, rp};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dut_cnt[i] - dut_snap[i] != ex[i]) begin
                failures++;
                $display("FAIL %s_%s dut_count=%0d exp=%0d", nm, names[i], dut_cnt[i] - dut_snap[i], ex[i]);
            end
            checks++;
            if (mdl_cnt[i] - mdl_snap[i] != ex[i]) begin
                failures++;
                $display("FAIL %s_%s_model model_count=%0d exp=%0d", nm, names[i], mdl_cnt[i] - mdl_snap[i], ex[i]);
            end
        end
        snap();
    endtask

    initial begin
        rst = 1'b1;
        btn_level = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({repeat_pulse, double_click, long_press, short_press, release_pulse, press_pulse} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {repeat_pulse, double_click, long_press, short_press, release_pulse, press_pulse});
        end
        drive(1'b0, 4);
        snap();

        drive(1'b1, 3);  drive(1'b0, 10);
        expect_counts("s1_short", 1, 1, 1, 0, 0, 0);

        drive(1'b1, 20); drive(1'b0, 10);
        expect_counts("s2_long", 1, 1, 0, 1, 0, EXP_REP20);

        drive(1'b1, 2);  drive(1'b0, 3);  drive(1'b1, 2);  drive(1'b0, 10);
        expect_counts("s3_double", 2, 2, 0, 0, 1, 0);

        drive(1'b1, 2);  drive(1'b0, 5);  drive(1'b1, 2);  drive(1'b0, 10);
        expect_counts("s4_gap_edge", 2, 2, 2, 0, 0, 0);

        drive(1'b1, 7);  drive(1'b0, 10);
        expect_counts("s5_seven", 1, 1, 1, 0, 0, 0);
        drive(1'b1, 8);  drive(1'b0, 10);
        expect_counts("s5_eight", 1, 1, 0, 1, 0, 0);

        drive(1'b1, 3);
        expect_counts("s6_pre", 1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(1'b1, 1);
        rst = 1'b0;
        drive(1'b1, 5);  drive(1'b0, 10);
        expect_counts("s6_held", 0, 0, 0, 0, 0, 0);
        drive(1'b1, 2);  drive(1'b0, 10);
        expect_counts("s6_repress", 1, 1, 1, 0, 0, 0);

        for (int it = 0; it < 200; it++) begin
            drive(1'b1, $urandom_range(1, 14));
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                drive(btn_level, 1);
                rst = 1'b0;
            end
            drive(1'b0, $urandom_range(1, 8));
        end
        drive(1'b0, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
